pdm_mod: RTL and testbench

First-order sigma-delta (PDM) modulator: converts a stream of WIDTH-bit unsigned samples into a 1-bit pulse-density stream whose ones-density equals sample/2^WIDTH. It is the transmit-side counterpart of the moving-average filter `MovAvr`, which low-pass filters such a 1-bit stream back into a multi-bit average. It sits between a sample producer (valid/ready) and any 1-bit consumer, including `MovAvr` for loopback benches.

---
 rtl/pdm_pkg.sv | 20 ++
 rtl/pdm_acc.sv | 31 +++
 rtl/pdm_mod.sv | 93 +++++++++
 tb/tb_pdm_mod.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared types and helpers for the first-order PDM modulator.
//   pdm_state_t     : IDLE (waiting for the first sample) / RUN (modulating)
//   cnt_width()     : bit width of the frame counter for a given OSR
//   PDM_WIDTH_DEF   : default sample width
//   PDM_OSR_DEF     : default output bits per sample
package pdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pdm_state_t;

    localparam int PDM_WIDTH_DEF = 8;
    localparam int PDM_OSR_DEF   = 16;

    function automatic int cnt_width(input int osr);
        return (osr > 1) ? $clog2(osr) : 1;
    endfunction

endpackage

// File: rtl/pdm_acc.sv
// pdm_acc: WIDTH-bit wrapping accumulator with combinational carry-out.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears acc
//   en     : acc advances by addend when high, holds when low
//   addend : value added each enabled cycle
//   acc    : accumulator residue
//   carry  : carry-out of acc + addend, i.e. the next pulse-density bit
module pdm_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] acc,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum   = {1'b0, acc} + {1'b0, addend};
    assign carry = sum[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en)
            acc <= sum[WIDTH-1:0];
    end

endmodule

// File: rtl/pdm_mod.sv
// pdm_mod: first-order sigma-delta modulator, WIDTH-bit samples to a 1-bit stream.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   en         : clock enable for the modulator (pending slot still loads when low)
//   in_data    : unsigned sample
//   in_valid   : sample offered
//   in_ready   : pending slot empty
//   pdm_out    : registered pulse-density bit
//   frame_tick : one-cycle pulse after the last bit of a frame
//   underrun   : one-cycle pulse when a frame ended with no pending sample
module pdm_mod
    import pdm_pkg::*;
#(
    parameter int WIDTH = PDM_WIDTH_DEF,
    parameter int OSR   = PDM_OSR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pdm_out,
    output logic             frame_tick,
    output logic             underrun
);

    localparam int CW = cnt_width(OSR);
    localparam logic [CW-1:0] LAST = CW'(OSR - 1);

    pdm_state_t       state, state_nxt;
    logic [WIDTH-1:0] pend, cur, acc;
    logic             pend_full, carry;
    logic [CW-1:0]    cnt;
    logic             run_en, frame_end, load, xfer;

    assign in_ready = !pend_full;

    // load only fires with pend_full set while xfer needs it clear, so the two never collide
    always_comb begin
        run_en    = en && (state == RUN);
        frame_end = run_en && (cnt == LAST);
        load      = pend_full && ((en && state == IDLE) || frame_end);
        xfer      = in_valid && in_ready;
        state_nxt = (state == IDLE && load) ? RUN : state;
    end

    pdm_acc #(.WIDTH(WIDTH)) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run_en),
        .addend (cur),
        .acc    (acc),
        .carry  (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            pend_full  <= 1'b0;
            cur        <= '0;
            cnt        <= '0;
            pdm_out    <= 1'b0;
            frame_tick <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (xfer) begin
                pend      <= in_data;
                pend_full <= 1'b1;
            end
            if (load) begin
                cur       <= pend;
                pend_full <= 1'b0;
            end
            if (frame_end || (load && state == IDLE))
                cnt <= '0;
            else if (run_en)
                cnt <= cnt + 1'b1;
            if (run_en)
                pdm_out <= carry;
            frame_tick <= frame_end;
            underrun   <= frame_end && !pend_full;
        end
    end

endmodule

// File: tb/tb_pdm_mod.sv
// tb_pdm_mod: self-checking bench for pdm_mod against a cumulative-sum density model.
module tb_pdm_mod;

    localparam int W   = 8;
    localparam int OSR = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, pdm_out, frame_tick, underrun;

    always #5 clk = ~clk;

    pdm_mod #(.WIDTH(W), .OSR(OSR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pdm_out    (pdm_out),
        .frame_tick (frame_tick),
        .underrun   (underrun)
    );

    int checks = 0;
    int failures = 0;

    // Model: a bit is 1 exactly when the running total of modulated samples
    // crosses a multiple of 2^W, which is what first-order sigma-delta means.
    logic [W-1:0] q[$];
    bit           m_run;
    logic [W-1:0] m_cur;
    longint       m_sum;
    int           m_pos;
    bit           m_pdm, m_tick, m_und;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_cur = '0; m_sum = 0; m_pos = 0;
        m_pdm = 0; m_tick = 0; m_und = 0;
    endtask

    task automatic check_all();
        chk("in_ready",   32'(in_ready),   32'(q.size() == 0));
        chk("pdm_out",    32'(pdm_out),    32'(m_pdm));
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        chk("underrun",   32'(underrun),   32'(m_und));
        chk("acc",        32'(dut.u_acc.acc), 32'(m_sum[W-1:0]));
    endtask

    task automatic cycle();
        bit           rdy, v, e;
        logic [W-1:0] d;
        longint       old;
        rdy = (q.size() == 0);
        v = in_valid; e = en; d = in_data;
        @(posedge clk);
        m_tick = 0; m_und = 0;
        if (e) begin
            if (!m_run) begin
                if (q.size() != 0) begin
                    m_cur = q.pop_front();
                    m_run = 1; m_pos = 0;
                end
            end else begin
                old   = m_sum;
                m_sum = m_sum + longint'(m_cur);
                m_pdm = ((m_sum >> W) != (old >> W));
                m_pos++;
                if (m_pos == OSR) begin
                    m_pos = 0; m_tick = 1;
                    if (q.size() != 0) m_cur = q.pop_front();
                    else m_und = 1;
                end
            end
        end
        if (v && rdy) q.push_back(d);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic offer(input logic [W-1:0] s);
        bit acc_ok, was;
        acc_ok = 0;
        in_valid = 1; in_data = s;
        for (int i = 0; i < 200 && !acc_ok; i++) begin
            was = in_ready;
            cycle();
            acc_ok = was;
        end
        in_valid = 0;
        chk("offer_accepted", 32'(acc_ok), 32'd1);
    endtask

    task automatic async_reset();
        #2 rst_n = 0;
        en = 0; in_valid = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst_n = 1;
        en = 1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1;
        en = 1;
        run(3);
        // 128: alternating bits, underrun each frame without refills
        offer(8'd128);
        run(3 * OSR + 4);
        async_reset();
        // 64 then 0: 0,0,0,1 pattern then silence
        offer(8'd64);
        offer(8'd0);
        run(3 * OSR);
        async_reset();
        // full scale: acc ends frame at 240
        offer(8'd255);
        run(OSR + 2);
        async_reset();
        // back-pressure chain with no underrun
        offer(8'd37);
        offer(8'd200);
        offer(8'd91);
        run(3 * OSR);
        async_reset();
        // en gap of 5 cycles in the middle of a frame
        offer(8'd64);
        run(8);
        en = 0;
        run(5);
        en = 1;
        run(2 * OSR);
        // reset at bit 7 of a running frame, then fresh 64 from acc=0
        async_reset();
        offer(8'd100);
        run(8);
        async_reset();
        offer(8'd64);
        run(OSR + 4);
        // random traffic with enable gaps
        for (int i = 0; i < 1500; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = W'($urandom);
            cycle();
            if (i == 700) async_reset();
        end
        in_valid = 0;
        en = 1;
        run(2 * OSR);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
